// File: rtl/pry_scan.sv
// Priority scanner: serialises a request vector into one-hot beats, one set bit per beat,
// in LSB-first or MSB-first order. Optional m_idx output enabled by macro PRY_SCAN_IDX_EN.
module pry_scan #(
  parameter int WIDTH     = 32,
  parameter     DIRECTION = "LSB",
  localparam int WIDTH_LOG = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_vld,
  output logic                 s_rdy,
  input  logic [WIDTH-1:0]     s_pry,
  output logic                 m_vld,
  input  logic                 m_rdy,
  output logic [WIDTH-1:0]     m_oht,
  output logic                 m_lst
`ifdef PRY_SCAN_IDX_EN
  ,
  output logic [WIDTH_LOG-1:0] m_idx
`endif
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] rem_s;
  logic [WIDTH-1:0] oht_s;
  logic             last_s;
  logic             load_s;

  // Priority pick: LSB-first isolates the lowest set bit, MSB-first the highest.
  generate
    if (DIRECTION == "MSB") begin : g_msb
      always_comb begin
        oht_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
          if (rem_r[i]) begin
            oht_s = {WIDTH{1'b0}};
            oht_s[i] = 1'b1;
          end else begin
            oht_s = oht_s;
          end
        end
      end
    end else begin : g_lsb
      assign oht_s = rem_r & (~rem_r + {{(WIDTH-1){1'b0}}, 1'b1});
    end
  endgenerate

  assign last_s = ((rem_r & ~oht_s) == {WIDTH{1'b0}});
  assign load_s = s_vld && (s_pry != {WIDTH{1'b0}});

  // Next-state, remainder update and handshake outputs.
  always_comb begin
    state_s = state_r;
    rem_s   = rem_r;
    s_rdy   = 1'b1;
    m_vld   = 1'b0;
    m_oht   = {WIDTH{1'b0}};
    m_lst   = 1'b0;
    case (state_r)
      IDLE: begin
        if (load_s) begin
          rem_s   = s_pry;
          state_s = BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        m_vld = 1'b1;
        m_oht = oht_s;
        m_lst = last_s;
        s_rdy = m_rdy & last_s;
        if (m_rdy) begin
          rem_s = rem_r & ~oht_s;
          if (last_s) begin
            // A new vector taken alongside the last beat continues with no bubble.
            if (load_s) begin
              rem_s   = s_pry;
              state_s = BUSY;
            end else begin
              state_s = IDLE;
            end
          end else begin
            state_s = BUSY;
          end
        end else begin
          state_s = BUSY;
        end
      end
      default: begin
        state_s = IDLE;
        rem_s   = {WIDTH{1'b0}};
      end
    endcase
  end

  // State and remainder registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      rem_r   <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      rem_r   <= rem_s;
    end
  end

`ifdef PRY_SCAN_IDX_EN
  // One-hot to binary; m_oht is zero when idle so the index falls to zero too.
  always_comb begin
    m_idx = {WIDTH_LOG{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (m_oht[i]) begin
        m_idx = m_idx | WIDTH_LOG'(i);
      end else begin
        m_idx = m_idx;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pry_scan.sv
// Directed self-checking bench for pry_scan at WIDTH=8, with LSB and MSB instances.
module tb_pry_scan;

  logic       clk;
  logic       rst_n;
  logic       s_vld;
  logic [7:0] s_pry;
  logic       m_rdy;

  logic       lsb_s_rdy, lsb_m_vld, lsb_m_lst;
  logic [7:0] lsb_m_oht;
  logic       msb_s_rdy, msb_m_vld, msb_m_lst;
  logic [7:0] msb_m_oht;
`ifdef PRY_SCAN_IDX_EN
  logic [2:0] lsb_m_idx;
  logic [2:0] msb_m_idx;
`endif

  int checks;
  int failures;

  pry_scan #(.WIDTH(8), .DIRECTION("LSB")) dut_lsb (
    .clk   (clk),
    .rst_n (rst_n),
    .s_vld (s_vld),
    .s_rdy (lsb_s_rdy),
    .s_pry (s_pry),
    .m_vld (lsb_m_vld),
    .m_rdy (m_rdy),
    .m_oht (lsb_m_oht),
    .m_lst (lsb_m_lst)
`ifdef PRY_SCAN_IDX_EN
    ,
    .m_idx (lsb_m_idx)
`endif
  );

  pry_scan #(.WIDTH(8), .DIRECTION("MSB")) dut_msb (
    .clk   (clk),
    .rst_n (rst_n),
    .s_vld (s_vld),
    .s_rdy (msb_s_rdy),
    .s_pry (s_pry),
    .m_vld (msb_m_vld),
    .m_rdy (m_rdy),
    .m_oht (msb_m_oht),
    .m_lst (msb_m_lst)
`ifdef PRY_SCAN_IDX_EN
    ,
    .m_idx (msb_m_idx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    s_vld = 1'b0;
    s_pry = 8'h00;
    m_rdy = 1'b0;
    #3;
    checks++;
    if ({lsb_s_rdy, lsb_m_vld, lsb_m_oht, lsb_m_lst} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL reset_lsb got rdy=%b vld=%b oht=%h lst=%b exp 1 0 00 0",
               lsb_s_rdy, lsb_m_vld, lsb_m_oht, lsb_m_lst);
    end
    checks++;
    if ({msb_s_rdy, msb_m_vld, msb_m_oht, msb_m_lst} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL reset_msb got rdy=%b vld=%b oht=%h lst=%b exp 1 0 00 0",
               msb_s_rdy, msb_m_vld, msb_m_oht, msb_m_lst);
    end
`ifdef PRY_SCAN_IDX_EN
    checks++;
    if (lsb_m_idx !== 3'd0) begin
      failures++;
      $display("FAIL reset_idx got=%0d exp=0", lsb_m_idx);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_scan_order();
    logic [7:0] exp_l [3];
    logic [7:0] exp_m [3];
    logic [2:0] idx_l [3];
    logic [2:0] idx_m [3];
    exp_l = '{8'h04, 8'h20, 8'h80};
    exp_m = '{8'h80, 8'h20, 8'h04};
    idx_l = '{3'd2, 3'd5, 3'd7};
    idx_m = '{3'd7, 3'd5, 3'd2};
    s_vld = 1'b1;
    s_pry = 8'hA4;
    m_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (lsb_s_rdy !== 1'b1 || lsb_m_vld !== 1'b0) begin
      failures++;
      $display("FAIL scan_idle got rdy=%b vld=%b exp 1 0", lsb_s_rdy, lsb_m_vld);
    end
    @(posedge clk);
    #1;
    s_vld = 1'b0;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      checks++;
      if (lsb_m_vld !== 1'b1 || lsb_m_oht !== exp_l[b] || lsb_m_lst !== (b == 2)) begin
        failures++;
        $display("FAIL scan_lsb beat%0d got vld=%b oht=%h lst=%b exp 1 %h %b",
                 b, lsb_m_vld, lsb_m_oht, lsb_m_lst, exp_l[b], (b == 2));
      end
      checks++;
      if (msb_m_vld !== 1'b1 || msb_m_oht !== exp_m[b] || msb_m_lst !== (b == 2)) begin
        failures++;
        $display("FAIL scan_msb beat%0d got vld=%b oht=%h lst=%b exp 1 %h %b",
                 b, msb_m_vld, msb_m_oht, msb_m_lst, exp_m[b], (b == 2));
      end
`ifdef PRY_SCAN_IDX_EN
      checks++;
      if (lsb_m_idx !== idx_l[b] || msb_m_idx !== idx_m[b]) begin
        failures++;
        $display("FAIL scan_idx beat%0d got lsb=%0d msb=%0d exp %0d %0d",
                 b, lsb_m_idx, msb_m_idx, idx_l[b], idx_m[b]);
      end
`endif
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checks++;
    if (lsb_m_vld !== 1'b0 || msb_m_vld !== 1'b0 || lsb_m_oht !== 8'h00) begin
      failures++;
      $display("FAIL scan_done got vld=%b/%b oht=%h exp 0/0 00", lsb_m_vld, msb_m_vld, lsb_m_oht);
    end
  endtask

  task automatic test_backpressure();
    @(posedge clk);
    #1;
    s_vld = 1'b1;
    s_pry = 8'h81;
    m_rdy = 1'b0;
    @(posedge clk);
    #1;
    s_vld = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (lsb_m_vld !== 1'b1 || lsb_m_oht !== 8'h01 || lsb_m_lst !== 1'b0 || lsb_s_rdy !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cyc%0d got vld=%b oht=%h lst=%b rdy=%b exp 1 01 0 0",
                 c, lsb_m_vld, lsb_m_oht, lsb_m_lst, lsb_s_rdy);
      end
    end
    @(posedge clk);
    #1;
    m_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (lsb_m_oht !== 8'h01 || lsb_m_lst !== 1'b0 || lsb_s_rdy !== 1'b0) begin
      failures++;
      $display("FAIL bp_beat0 got oht=%h lst=%b rdy=%b exp 01 0 0", lsb_m_oht, lsb_m_lst, lsb_s_rdy);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (lsb_m_vld !== 1'b1 || lsb_m_oht !== 8'h80 || lsb_m_lst !== 1'b1 || lsb_s_rdy !== 1'b1) begin
      failures++;
      $display("FAIL bp_beat1 got vld=%b oht=%h lst=%b rdy=%b exp 1 80 1 1",
               lsb_m_vld, lsb_m_oht, lsb_m_lst, lsb_s_rdy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_zero_vector();
    s_vld = 1'b1;
    s_pry = 8'h00;
    m_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (lsb_s_rdy !== 1'b1) begin
      failures++;
      $display("FAIL zero_rdy got=%b exp=1", lsb_s_rdy);
    end
    @(posedge clk);
    #1;
    s_vld = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (lsb_m_vld !== 1'b0 || lsb_s_rdy !== 1'b1 || msb_m_vld !== 1'b0) begin
        failures++;
        $display("FAIL zero_idle cyc%0d got vld=%b rdy=%b exp 0 1", c, lsb_m_vld, lsb_s_rdy);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_o [3];
    logic       exp_l [3];
    exp_o = '{8'h10, 8'h01, 8'h02};
    exp_l = '{1'b1, 1'b0, 1'b1};
    s_vld = 1'b1;
    s_pry = 8'h10;
    m_rdy = 1'b1;
    @(posedge clk);
    #1;
    s_pry = 8'h03;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      checks++;
      if (lsb_m_vld !== 1'b1 || lsb_m_oht !== exp_o[b] || lsb_m_lst !== exp_l[b]) begin
        failures++;
        $display("FAIL b2b beat%0d got vld=%b oht=%h lst=%b exp 1 %h %b",
                 b, lsb_m_vld, lsb_m_oht, lsb_m_lst, exp_o[b], exp_l[b]);
      end
      @(posedge clk);
      #1;
      s_vld = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (lsb_m_vld !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end got vld=%b exp=0", lsb_m_vld);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #1;
    s_vld = 1'b1;
    s_pry = 8'hFF;
    m_rdy = 1'b1;
    @(posedge clk);
    #1;
    s_vld = 1'b0;
    @(negedge clk);
    checks++;
    if (lsb_m_vld !== 1'b1 || lsb_m_oht !== 8'h01) begin
      failures++;
      $display("FAIL rmid_first got vld=%b oht=%h exp 1 01", lsb_m_vld, lsb_m_oht);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (lsb_m_vld !== 1'b0 || lsb_m_oht !== 8'h00 || lsb_s_rdy !== 1'b1 || msb_m_vld !== 1'b0) begin
      failures++;
      $display("FAIL rmid_async got vld=%b oht=%h rdy=%b exp 0 00 1", lsb_m_vld, lsb_m_oht, lsb_s_rdy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (lsb_m_vld !== 1'b0 || msb_m_vld !== 1'b0) begin
        failures++;
        $display("FAIL rmid_after cyc%0d got vld=%b/%b exp 0/0", c, lsb_m_vld, msb_m_vld);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_scan_order();
    test_backpressure();
    test_zero_vector();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
